// File: rtl/acc_pkg.sv
// acc_pkg: shared types and constants for the accelerator datapath.
//   data_t      - 32-bit FPU result word written to the CPU regfile
//   status_t    - 5-bit IEEE exception flags {NV, DZ, OF, UF, NX}
//   reg_addr_t  - 5-bit architectural register address
//   tag_t       - operation tag travelling with the FPU request/result
//   fpu_resp_t  - FPU output bundle (result, status, tag)
//   wb_entry_t  - one writeback-buffer slot (destination, data)
package acc_pkg;

    localparam int DATA_W     = 32;
    localparam int FLAGS_W    = 5;
    localparam int REG_ADDR_W = 5;
    localparam int WB_DEPTH   = 4;
    localparam int HZ_PORTS   = 3;

    typedef logic [DATA_W-1:0]     data_t;
    typedef logic [FLAGS_W-1:0]    status_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    typedef struct packed {
        reg_addr_t rd;
    } tag_t;

    typedef struct packed {
        data_t   result;
        status_t status;
        tag_t    tag;
    } fpu_resp_t;

    typedef struct packed {
        reg_addr_t rd;
        data_t     data;
    } wb_entry_t;

endpackage

// File: rtl/acc_wb_buffer.sv
// acc_wb_buffer: FIFO between the FPU output port and the CPU regfile write
// port. Results are queued in acceptance order and drained whenever the CPU
// grants the write port. Also reports pending destinations for RAW hazard
// checks and accumulates sticky IEEE exception flags.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   fpu_out_valid_i/    FPU result handshake; ready is low while full or
//   fpu_out_ready_o     in reset
//   fpu_resp_i          result, status and tag (tag.rd = destination)
//   flush_i             discard all buffered entries
//   waddr_o/wdata_o/    regfile write request from the head entry (zero
//   wren_o              when empty)
//   wr_grant_i          CPU write port free this cycle; pop = wren && grant
//   hz_addr_i/hz_o      source registers to check / pending-hit flags
//   fflags_o/           sticky OR of accepted status values / clear
//   fflags_clr_i
//   count_o/empty_o     occupancy
module acc_wb_buffer
    import acc_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       fpu_out_valid_i,
    output logic                       fpu_out_ready_o,
    input  fpu_resp_t                  fpu_resp_i,
    input  logic                       flush_i,
    output reg_addr_t                  waddr_o,
    output data_t                      wdata_o,
    output logic                       wren_o,
    input  logic                       wr_grant_i,
    input  reg_addr_t                  hz_addr_i [HZ_PORTS],
    output logic [HZ_PORTS-1:0]        hz_o,
    output status_t                    fflags_o,
    input  logic                       fflags_clr_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    wb_entry_t         mem [DEPTH];
    logic [DEPTH-1:0]  valid_reg;
    logic [DEPTH-1:0]  valid_next;
    logic [PW-1:0]     rd_ptr_reg;
    logic [PW-1:0]     wr_ptr_reg;
    logic [CW-1:0]     count_reg;
    logic [CW-1:0]     count_next;
    status_t           fflags_reg;
    status_t           fflags_next;

    logic      full;
    logic      empty;
    logic      push;
    logic      store;
    logic      pop;
    wb_entry_t head;

    assign full  = (count_reg == CW'(DEPTH));
    assign empty = (count_reg == '0);

    // Ready deliberately ignores the grant: a full buffer never accepts,
    // even while it is popping, so ready stays free of the CPU timing path.
    assign fpu_out_ready_o = !full && !rst_i;
    assign push            = fpu_out_valid_i && fpu_out_ready_o;

    // x0 results complete the handshake (and update flags) but are never
    // written; a push racing a flush is dropped as well.
    assign store = push && (fpu_resp_i.tag.rd != '0) && !flush_i;

    assign wren_o = !empty;
    assign pop    = wren_o && wr_grant_i;

    assign head    = mem[rd_ptr_reg];
    assign waddr_o = empty ? '0 : head.rd;
    assign wdata_o = empty ? '0 : head.data;

    assign count_o  = count_reg;
    assign empty_o  = empty;
    assign fflags_o = fflags_reg;

    // Push and pop can only hit the same slot when the buffer is empty
    // (no pop) or full (no push), so the order of the two updates is moot.
    always_comb begin
        valid_next = valid_reg;
        if (pop) begin
            valid_next[rd_ptr_reg] = 1'b0;
        end
        if (store) begin
            valid_next[wr_ptr_reg] = 1'b1;
        end
    end

    assign count_next = count_reg + CW'(store) - CW'(pop);

    // Clear-then-merge when clear and push coincide.
    always_comb begin
        fflags_next = fflags_reg;
        if (fflags_clr_i) begin
            fflags_next = '0;
        end
        if (push) begin
            fflags_next = fflags_next | fpu_resp_i.status;
        end
    end

    // Storage carries no reset; the valid vector and count guard every read.
    always_ff @(posedge clk_i) begin
        if (store) begin
            mem[wr_ptr_reg] <= '{rd: fpu_resp_i.tag.rd, data: fpu_resp_i.result};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            valid_reg  <= '0;
            fflags_reg <= '0;
        end else begin
            fflags_reg <= fflags_next;
            if (flush_i) begin
                rd_ptr_reg <= '0;
                wr_ptr_reg <= '0;
                count_reg  <= '0;
                valid_reg  <= '0;
            end else begin
                if (store) begin
                    wr_ptr_reg <= wr_ptr_reg + PW'(1);
                end
                if (pop) begin
                    rd_ptr_reg <= rd_ptr_reg + PW'(1);
                end
                count_reg <= count_next;
                valid_reg <= valid_next;
            end
        end
    end

    // Hazard compare: every check port against every valid slot. x0 never
    // reports a hazard since it is never stored and is hardwired to zero.
    logic [HZ_PORTS-1:0][DEPTH-1:0] hit;

    genvar gi, gj;
    generate
        for (gi = 0; gi < HZ_PORTS; gi++) begin : g_hz_port
            for (gj = 0; gj < DEPTH; gj++) begin : g_hz_slot
                assign hit[gi][gj] = valid_reg[gj] && (mem[gj].rd == hz_addr_i[gi]);
            end
            assign hz_o[gi] = (hz_addr_i[gi] != '0) && (|hit[gi]);
        end
    endgenerate

endmodule
